// File: rtl/line_fill_pkg.sv
// line_fill_pkg: default line geometry, pixel/line-index widths and FSM state codes shared by the line fill sequencer
package line_fill_pkg;
  localparam int ADDR_W_DEF = 22;
  localparam int H_ACTIVE_DEF = 800;
  localparam int LINE_STRIDE_DEF = 800;
  localparam int BURST_PX_DEF = 32;
  localparam int LEN_W_DEF = 6;
  localparam int PX_W = 24;
  localparam int LN_W = 10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/line_fill_ctrl_if.sv
// line_fill_ctrl_if: PSRAM burst-read bus; master drives rd_req/rd_addr/rd_len, slave returns rd_ack/rd_valid/rd_data
interface line_fill_ctrl_if
  import line_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_valid;
  logic [PX_W-1:0]   rd_data;
  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_valid, rd_data);
  modport slave (input rd_req, rd_addr, rd_len, output rd_ack, rd_valid, rd_data);
endinterface

// File: rtl/line_fill_ctrl_burst_len_calc.sv
// burst_len_calc: in rem/addr, out len=min(BURST_PX, rem) and next_addr=addr+len (wrapping)
module burst_len_calc #(
  parameter int ADDR_W = 22,
  parameter int BURST_PX = 32,
  parameter int LEN_W = 6,
  parameter int REM_W = 10
) (
  input  logic [REM_W-1:0]  rem,
  input  logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] next_addr
);
  always_comb begin
    len = (int'(rem) > BURST_PX) ? LEN_W'(BURST_PX) : LEN_W'(rem);
    next_addr = addr + ADDR_W'(len);
  end
endmodule

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: turns line requests (enable/line_req/line_num/frame_base) into PSRAM bursts on rd and line-buffer writes (lb_*), with busy/line_done/overrun status
module line_fill_ctrl
  import line_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int LINE_STRIDE = LINE_STRIDE_DEF,
  parameter int BURST_PX = BURST_PX_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk_psram,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              line_req,
  input  logic [LN_W-1:0]   line_num,
  line_fill_ctrl_if.master  rd,
  output logic [LN_W-1:0]   lb_wr_addr,
  output logic [PX_W-1:0]   lb_wr_data,
  output logic              lb_wr_en,
  output logic              lb_bank,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  input  logic              clr_overrun
);
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [LN_W-1:0] rem_q, rem_d, pend_q, pend_d, waddr_q, waddr_d, start_num;
  logic [LEN_W-1:0] beats_q, beats_d, len;
  logic [PX_W-1:0] wdata_q, wdata_d;
  logic pend_v_q, pend_v_d, bank_q, bank_d, ovr_q, ovr_d, done_q, done_d, wen_q, wen_d;
  logic req_in, busy_c, start, acked, beat, last;

  burst_len_calc #(.ADDR_W(ADDR_W), .BURST_PX(BURST_PX), .LEN_W(LEN_W), .REM_W(LN_W)) u_len (
    .rem(rem_q), .addr(addr_q), .len(len), .next_addr(next_addr)
  );

  always_comb begin
    req_in = line_req & enable;
    busy_c = state_q != S_IDLE;
    // from DONE a request arriving in that same cycle is the newest pending line and is taken directly
    start = (state_q == S_IDLE && req_in) || (state_q == S_DONE && (pend_v_q || req_in));
    start_num = req_in ? line_num : pend_q;
    acked = state_q == S_REQ && rd.rd_ack;
    beat = state_q == S_DATA && rd.rd_valid;
    last = beat && beats_q == LEN_W'(1);
    state_d = start ? S_REQ : acked ? S_DATA : last ? (rem_q == LN_W'(1) ? S_DONE : S_REQ) :
              state_q == S_DONE ? S_IDLE : state_q;
    addr_d = start ? frame_base + ADDR_W'(int'(start_num) * LINE_STRIDE) : acked ? next_addr : addr_q;
    rem_d = start ? LN_W'(H_ACTIVE) : beat ? rem_q - LN_W'(1) : rem_q;
    beats_d = acked ? len : beat ? beats_q - LEN_W'(1) : beats_q;
    bank_d = start ? ~bank_q : bank_q;
    pend_v_d = state_q == S_DONE ? 1'b0 : (busy_c && req_in) ? 1'b1 : pend_v_q;
    pend_d = (busy_c && req_in) ? line_num : pend_q;
    ovr_d = (busy_c && req_in && pend_v_q) ? 1'b1 : clr_overrun ? 1'b0 : ovr_q;
    wen_d = beat;
    // write pointer is implied by the pixels still outstanding on this line
    waddr_d = beat ? LN_W'(H_ACTIVE) - rem_q : waddr_q;
    wdata_d = beat ? rd.rd_data : wdata_q;
    done_d = state_q == S_DONE;
  end

  always_ff @(posedge clk_psram) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      beats_q <= '0;
      bank_q <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q <= '0;
      ovr_q <= 1'b0;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      beats_q <= beats_d;
      bank_q <= bank_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q <= done_d;
    end
  end

  assign rd.rd_req = state_q == S_REQ;
  assign rd.rd_addr = state_q == S_REQ ? addr_q : '0;
  assign rd.rd_len = state_q == S_REQ ? len : '0;
  assign lb_wr_addr = waddr_q;
  assign lb_wr_data = wdata_q;
  assign lb_wr_en = wen_q;
  assign lb_bank = bank_q;
  assign busy = busy_c;
  assign line_done = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: table-driven, directed and randomized checks of line_fill_ctrl against a line/burst reference model
module tb_line_fill_ctrl;
  localparam int AW = 22, H = 800, STRIDE = 800, BP = 32, H1 = 100;
  logic clk_psram = 0, rst = 1, enable = 0, line_req = 0, clr_overrun = 0;
  logic [AW-1:0] frame_base = '0;
  logic [9:0] line_num = '0;
  logic [9:0] lb_wr_addr;
  logic [23:0] lb_wr_data;
  logic lb_wr_en, lb_bank, busy, line_done, overrun;
  logic en1 = 0, req1 = 0;
  logic [9:0] wa1;
  logic [23:0] wd1;
  logic we1, bank1, busy1, done1, ovr1;
  int total = 0, bad = 0;

  line_fill_ctrl_if #(.ADDR_W(AW), .LEN_W(6)) bus ();
  line_fill_ctrl_if #(.ADDR_W(AW), .LEN_W(6)) bus1 ();

  line_fill_ctrl #(.ADDR_W(AW), .H_ACTIVE(H), .LINE_STRIDE(STRIDE), .BURST_PX(BP), .LEN_W(6)) dut (
    .clk_psram(clk_psram), .rst(rst), .enable(enable), .frame_base(frame_base), .line_req(line_req),
    .line_num(line_num), .rd(bus), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .lb_wr_en(lb_wr_en),
    .lb_bank(lb_bank), .busy(busy), .line_done(line_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  line_fill_ctrl #(.ADDR_W(AW), .H_ACTIVE(H1), .LINE_STRIDE(H1), .BURST_PX(BP), .LEN_W(6)) dut1 (
    .clk_psram(clk_psram), .rst(rst), .enable(en1), .frame_base(22'd0), .line_req(req1),
    .line_num(10'd1), .rd(bus1), .lb_wr_addr(wa1), .lb_wr_data(wd1), .lb_wr_en(we1),
    .lb_bank(bank1), .busy(busy1), .line_done(done1), .overrun(ovr1), .clr_overrun(1'b0)
  );

  always #5 clk_psram = ~clk_psram;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] base; logic bank; } line_t;
  line_t bq[$];
  logic [23:0] dq[$];
  int wr_idx = 0, bidx = 0, owed = 0, lines_done = 0, wcnt = 0, s_dly = 0, ack_dly = 0, gap = 0, ph = 0;
  logic in_req = 0, acked = 0, stale = 0, prev_wr = 0, exp_bank = 0;
  logic [AW-1:0] s_addr = '0;
  logic [5:0] s_len = '0;

  // PSRAM responder plus monitor for the main DUT
  initial begin
    bus.rd_ack = 0; bus.rd_valid = 0; bus.rd_data = '0;
    forever begin
      @(negedge clk_psram);
      if (lb_wr_en) begin
        if (dq.size() == 0) chk("spurious_write", 1, 0);
        else begin
          chk("wr_data", lb_wr_data, dq.pop_front());
          chk("wr_addr", lb_wr_addr, wr_idx);
          wr_idx++;
        end
      end
      if (line_done) begin
        chk("done_after_last_write", prev_wr, 1);
        chk("writes_per_line", wr_idx, H);
        chk("bursts_per_line", bidx, (H + BP - 1) / BP);
        lines_done++; wr_idx = 0; bidx = 0;
        if (bq.size() != 0) void'(bq.pop_front());
      end
      prev_wr = lb_wr_en;
      if (rst) begin
        bq.delete(); wr_idx = 0; bidx = 0; in_req = 0; acked = 0; stale = 1; bus.rd_ack = 0;
      end else if (acked) begin
        chk("rd_req_drops_after_ack", bus.rd_req, 0);
        owed += int'(s_len); bidx++; acked = 0; bus.rd_ack = 0;
      end else if (bus.rd_req) begin
        if (!in_req) begin
          if (bq.size() == 0) chk("spurious_rd_req", 1, 0);
          else begin
            chk("rd_addr", bus.rd_addr, (int'(bq[0].base) + bidx * BP) % (1 << AW));
            chk("rd_len", bus.rd_len, (H - bidx * BP) < BP ? H - bidx * BP : BP);
            if (bidx == 0) chk("lb_bank", lb_bank, bq[0].bank);
          end
          s_addr = bus.rd_addr; s_len = bus.rd_len; in_req = 1; wcnt = 0;
          s_dly = ack_dly < 0 ? int'($urandom_range(0, 4)) : ack_dly;
        end else begin
          chk("rd_addr_stable", bus.rd_addr, s_addr);
          chk("rd_len_stable", bus.rd_len, s_len);
        end
        if (wcnt >= s_dly) begin bus.rd_ack = 1; acked = 1; in_req = 0; end
        else wcnt++;
      end else if (in_req) chk("rd_req_held_until_ack", 0, 1);
      if (owed > 0 && (gap == 0 || (gap == 1 && ph % 3 == 0) || (gap == 2 && $urandom_range(0, 1) == 1))) begin
        bus.rd_valid = 1; bus.rd_data = 24'($urandom); owed--;
        if (!stale) dq.push_back(bus.rd_data);
      end else begin
        bus.rd_valid = 0; bus.rd_data = 24'($urandom);
      end
      if (owed > 0) ph++;
      else begin ph = 0; if (!rst) stale = 0; end
    end
  end

  // responder for the short-line DUT: instant ack, rd_valid always high (ignored outside bursts)
  int lens1[$], addrs1[$];
  int wcount1 = 0, last_wa1 = -1, dones1 = 0;
  initial begin
    bus1.rd_ack = 0; bus1.rd_valid = 0; bus1.rd_data = '0;
    forever begin
      @(negedge clk_psram);
      if (bus1.rd_req && !bus1.rd_ack) begin lens1.push_back(int'(bus1.rd_len)); addrs1.push_back(int'(bus1.rd_addr)); end
      if (we1) begin wcount1++; last_wa1 = int'(wa1); end
      if (done1) dones1++;
      bus1.rd_ack = bus1.rd_req; bus1.rd_valid = 1; bus1.rd_data = bus1.rd_data + 24'd1;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk_psram); #1; end
  endtask

  task automatic expect_base(logic [AW-1:0] base);
    exp_bank = ~exp_bank;
    bq.push_back('{base, exp_bank});
  endtask

  task automatic pulse(logic [9:0] num);
    line_num = num; line_req = 1; tick(); line_req = 0;
  endtask

  task automatic wait_done(int n, int budget);
    int c = 0;
    while (lines_done < n && c < budget) begin tick(); c++; end
    chk("line_done_in_time", lines_done, n);
  endtask

  typedef struct { logic [9:0] num; logic [AW-1:0] fb; int dly; int gap; logic [AW-1:0] base; } vec_t;
  vec_t tbl[5];
  int exp_len1[4];

  initial begin
    int n, c;
    logic [9:0] rn;
    tbl[0] = '{10'd2,    22'd0,       0, 0, 22'd1600};
    tbl[1] = '{10'd0,    22'd1000,    5, 1, 22'd1000};
    tbl[2] = '{10'd1023, 22'd4194048, 1, 2, 22'd818144};
    tbl[3] = '{10'd0,    22'd4194204, 2, 0, 22'd4194204};
    tbl[4] = '{10'd10,   22'd12345,   0, 2, 22'd20345};
    exp_len1 = '{32, 32, 32, 4};
    enable = 1;
    tick(3);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_len", bus.rd_len, 0);
    chk("rst_lb_wr_en", lb_wr_en, 0);
    chk("rst_lb_bank", lb_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    tick(2);
    en1 = 1; req1 = 1; tick(); req1 = 0;
    foreach (tbl[i]) begin
      n = lines_done;
      ack_dly = tbl[i].dly; gap = tbl[i].gap; frame_base = tbl[i].fb;
      expect_base(tbl[i].base);
      pulse(tbl[i].num);
      chk("busy_after_req", busy, 1);
      wait_done(n + 1, 4000);
      chk("idle_after_line", busy, 0);
      chk("line_done_one_cycle", line_done, 0);
      chk("bank_after_line", lb_bank, exp_bank);
    end
    for (int i = 0; i < 4; i++) begin
      n = lines_done;
      ack_dly = -1; gap = 2;
      frame_base = AW'($urandom); rn = 10'($urandom_range(0, 1023));
      expect_base(AW'(int'(frame_base) + int'(rn) * STRIDE));
      pulse(rn);
      wait_done(n + 1, 4000);
      tick($urandom_range(0, 3));
    end
    ack_dly = 0; gap = 0; frame_base = '0;
    n = lines_done;
    expect_base(22'd2400);
    pulse(10'd3);
    tick(20); pulse(10'd5);
    chk("single_pending_no_overrun", overrun, 0);
    tick(5); pulse(10'd6);
    chk("overrun_set", overrun, 1);
    expect_base(22'd4800);
    wait_done(n + 2, 4000);
    chk("no_line5_fill", busy, 0);
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("overrun_cleared", overrun, 0);
    n = lines_done;
    expect_base(22'd5600);
    pulse(10'd7);
    tick(10); pulse(10'd8);
    clr_overrun = 1; pulse(10'd9); clr_overrun = 0;
    chk("overrun_set_beats_clear", overrun, 1);
    expect_base(22'd7200);
    wait_done(n + 2, 4000);
    clr_overrun = 1; tick(); clr_overrun = 0;
    chk("overrun_cleared_again", overrun, 0);
    enable = 0; pulse(10'd7); tick(20);
    chk("enable_low_not_busy", busy, 0);
    chk("enable_low_no_bank_toggle", lb_bank, exp_bank);
    enable = 1;
    n = lines_done;
    expect_base(22'd6400);
    pulse(10'd8);
    tick(30); enable = 0;
    wait_done(n + 1, 4000);
    enable = 1;
    n = lines_done;
    expect_base(22'd800);
    pulse(10'd1);
    c = 0;
    while (wr_idx < 10 && c < 200) begin tick(); c++; end
    chk("ten_beats_before_reset", wr_idx >= 10, 1);
    rst = 1; tick();
    chk("mid_rst_rd_req", bus.rd_req, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_rd_len", bus.rd_len, 0);
    chk("mid_rst_lb_wr_en", lb_wr_en, 0);
    chk("mid_rst_lb_wr_addr", lb_wr_addr, 0);
    chk("mid_rst_lb_wr_data", lb_wr_data, 0);
    chk("mid_rst_lb_bank", lb_bank, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_line_done", line_done, 0);
    rst = 0; exp_bank = 0;
    c = 0;
    while ((owed != 0 || stale) && c < 500) begin tick(); c++; end
    chk("stale_beats_drained", owed, 0);
    chk("no_done_for_aborted_line", lines_done, n);
    tick(3);
    expect_base(22'd3200);
    pulse(10'd4);
    wait_done(n + 1, 4000);
    chk("fresh_line_bank", lb_bank, 1);
    chk("h100_burst_count", lens1.size(), 4);
    for (int i = 0; i < 4 && i < lens1.size(); i++) begin
      chk("h100_rd_len", lens1[i], exp_len1[i]);
      chk("h100_rd_addr", addrs1[i], H1 + 32 * i);
    end
    chk("h100_write_count", wcount1, H1);
    chk("h100_last_wr_addr", last_wa1, H1 - 1);
    chk("h100_line_done_count", dones1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
